// File: rtl/riscv_cpu_pkg.sv
// Shared core types: ALU opcodes, divider state encoding and widths.
// The divider reads operator bit0 as "signed" and bit1 as "remainder".
package riscv_cpu_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ALU_OP_WIDTH  = 5;
    localparam int DIV_CNT_WIDTH = $clog2(DATA_WIDTH);

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 5'h00,
        ALU_SUB  = 5'h01,
        ALU_XOR  = 5'h02,
        ALU_OR   = 5'h03,
        ALU_AND  = 5'h04,
        ALU_SLL  = 5'h05,
        ALU_SRL  = 5'h06,
        ALU_SRA  = 5'h07,
        ALU_SLT  = 5'h08,
        ALU_SLTU = 5'h09,
        ALU_MUL  = 5'h10,
        ALU_DIVU = 5'h14,
        ALU_DIV  = 5'h15,
        ALU_REMU = 5'h16,
        ALU_REM  = 5'h17
    } alu_opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } div_state_e;

    function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
        return op inside {ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};
    endfunction

endpackage

// File: rtl/riscv_cpu_div_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for restoring the sign of quotient/remainder.
module riscv_cpu_div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/riscv_cpu_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Define RISCV_CPU_DIV_EARLY_OUT_EN to finish div-by-zero/overflow at once.
module riscv_cpu_div #(
    parameter int DATA_WIDTH = riscv_cpu_pkg::DATA_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 enable_i,
    input  logic [riscv_cpu_pkg::ALU_OP_WIDTH-1:0] operator_i,
    input  logic [DATA_WIDTH-1:0]                op_a_i,
    input  logic [DATA_WIDTH-1:0]                op_b_i,
    input  logic                                 kill_i,
    input  logic                                 ex_ready_i,
    output logic                                 ready_o,
    output logic                                 valid_o,
    output logic [DATA_WIDTH-1:0]                result_o
);

    import riscv_cpu_pkg::*;

    localparam int CW  = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    div_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  rem_sel_q, rem_sel_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  valid_q, valid_d;

    logic                  a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic [DATA_WIDTH:0]   r_shift, diff;
    logic                  qbit;
    logic [DATA_WIDTH-1:0] rem_step, quo_step;
    logic [DATA_WIDTH-1:0] quo_fix, rem_fix;
    logic                  div_zero;
    logic [DATA_WIDTH-1:0] final_res;

    assign a_neg = operator_i[0] & op_a_i[MSB];
    assign b_neg = operator_i[0] & op_b_i[MSB];

    riscv_cpu_div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_a (
        .data_i (op_a_i),
        .neg_i  (a_neg),
        .data_o (a_mag)
    );

    riscv_cpu_div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_b (
        .data_i (op_b_i),
        .neg_i  (b_neg),
        .data_o (b_mag)
    );

    // quo_q doubles as the dividend shift register; quotient bits enter at LSB
    assign r_shift  = {rem_q, quo_q[MSB]};
    assign diff     = r_shift - {1'b0, dvs_q};
    assign qbit     = ~diff[DATA_WIDTH];
    assign rem_step = qbit ? diff[MSB:0] : r_shift[MSB:0];
    assign quo_step = {quo_q[MSB-1:0], qbit};

    riscv_cpu_div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_q (
        .data_i (quo_step),
        .neg_i  (neg_quo_q),
        .data_o (quo_fix)
    );

    riscv_cpu_div_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_r (
        .data_i (rem_step),
        .neg_i  (neg_rem_q),
        .data_o (rem_fix)
    );

    // Signed overflow falls out of the datapath; only div-by-zero is patched
    assign div_zero  = (dvs_q == '0);
    assign final_res = rem_sel_q ? (div_zero ? op_a_q : rem_fix)
                                 : (div_zero ? '1 : quo_fix);

`ifdef RISCV_CPU_DIV_EARLY_OUT_EN
    logic                  in_zero, in_ovf;
    logic [DATA_WIDTH-1:0] min_val, early_res;

    assign min_val   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    assign in_zero   = (op_b_i == '0);
    assign in_ovf    = operator_i[0] & (op_a_i == min_val) & (&op_b_i);
    assign early_res = operator_i[1] ? (in_zero ? op_a_i : '0)
                                     : (in_zero ? '1 : min_val);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_a_d    = op_a_q;
        result_d  = result_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        valid_d   = valid_q;

        if (kill_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable_i && is_div_op(operator_i)) begin
                        state_d   = DIVIDE;
                        cnt_d     = CW'(DATA_WIDTH - 1);
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        op_a_d    = op_a_i;
                        rem_sel_d = operator_i[1];
                        neg_quo_d = operator_i[0] & (op_a_i[MSB] ^ op_b_i[MSB]);
                        neg_rem_d = a_neg;
`ifdef RISCV_CPU_DIV_EARLY_OUT_EN
                        if (in_zero || in_ovf) begin
                            state_d  = FINISH;
                            cnt_d    = '0;
                            valid_d  = 1'b1;
                            result_d = early_res;
                        end
`endif
                    end
                end
                DIVIDE: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == '0) begin
                        state_d  = FINISH;
                        valid_d  = 1'b1;
                        result_d = final_res;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FINISH: begin
                    if (ex_ready_i) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            op_a_q    <= '0;
            result_q  <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            op_a_q    <= op_a_d;
            result_q  <= result_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            valid_q   <= valid_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_cpu_div.sv
// Directed vector bench for riscv_cpu_div: table of DIV/REM cases plus
// kill, reset, hold and ignored-operator sequences.
module tb_riscv_cpu_div;

    import riscv_cpu_pkg::*;

    typedef struct {
        logic [ALU_OP_WIDTH-1:0] op;
        logic [31:0]             a;
        logic [31:0]             b;
        logic [31:0]             exp;
        logic                    special;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    enable = 1'b0;
    logic                    kill = 1'b0;
    logic                    ex_ready = 1'b0;
    logic [ALU_OP_WIDTH-1:0] op = ALU_ADD;
    logic [31:0]             a = '0;
    logic [31:0]             b = '0;
    logic                    ready;
    logic                    valid;
    logic [31:0]             res;

    int checks = 0;
    int errors = 0;

    vec_t vecs[17];

    always #5 clk = ~clk;

    riscv_cpu_div dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .operator_i (op),
        .op_a_i     (a),
        .op_b_i     (b),
        .kill_i     (kill),
        .ex_ready_i (ex_ready),
        .ready_o    (ready),
        .valid_o    (valid),
        .result_o   (res)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(input logic [ALU_OP_WIDTH-1:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        check("ready_before_accept", {31'd0, ready}, 32'd1);
        op     = o;
        a      = x;
        b      = y;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        op     = ALU_ADD;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(negedge clk);
        ex_ready = 1'b1;
        check("ready_low_in_finish", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        ex_ready = 1'b0;
        check("valid_low_after_retire", {31'd0, valid}, 32'd0);
        check("ready_high_after_retire", {31'd0, ready}, 32'd1);
    endtask

    task automatic no_valid_for(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1;
        end
        check(name, seen, 0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        int exp_lat;
        exp_lat = 32;
`ifdef RISCV_CPU_DIV_EARLY_OUT_EN
        if (v.special) exp_lat = 0;
`endif
        start(v.op, v.a, v.b);
        wait_valid(lat);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, res, v.exp);
        retire();
    endtask

    initial begin
        vecs[0]  = '{ALU_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{ALU_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{ALU_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0};
        vecs[3]  = '{ALU_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0};
        vecs[4]  = '{ALU_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[5]  = '{ALU_REM,  32'd5,          32'd0,          32'd5,          1'b1};
        vecs[6]  = '{ALU_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
        vecs[7]  = '{ALU_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[8]  = '{ALU_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0};
        vecs[9]  = '{ALU_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0};
        vecs[10] = '{ALU_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   1'b0};
        vecs[11] = '{ALU_REMU, 32'hFFFFFFFF,   32'h10,         32'hF,          1'b0};
        vecs[12] = '{ALU_DIVU, 32'h80000000,   32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[13] = '{ALU_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1'b1};
        vecs[14] = '{ALU_DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[15] = '{ALU_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0};
        vecs[16] = '{ALU_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          1'b0};

        #2 rst_n = 1'b0;
        #1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_result", res, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Non-divide operator must be ignored
        @(negedge clk);
        op     = ALU_ADD;
        a      = 32'd9;
        b      = 32'd3;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        check("ignore_add_ready", {31'd0, ready}, 32'd1);
        no_valid_for(35, "ignore_add_no_valid");

        // Kill on the 10th DIVIDE cycle
        start(ALU_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("busy_before_kill", {31'd0, ready}, 32'd0);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_ready", {31'd0, ready}, 32'd1);
        check("kill_valid", {31'd0, valid}, 32'd0);
        no_valid_for(40, "kill_no_valid");
        run_vec(vecs[0], "after_kill");

        // Hold in FINISH with a competing request
        begin
            int lat;
            start(ALU_DIV, 32'hFFFFFFF9, 32'd2);
            wait_valid(lat);
            check("hold_latency", lat, 32);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                enable = 1'b1;
                op     = ALU_DIV;
                a      = 32'd1;
                b      = 32'd1;
                @(posedge clk);
                #1;
                check("hold_valid", {31'd0, valid}, 32'd1);
                check("hold_result", res, 32'hFFFFFFFD);
                check("hold_ready", {31'd0, ready}, 32'd0);
            end
            enable = 1'b0;
            op     = ALU_ADD;
            retire();
            no_valid_for(35, "hold_no_extra_accept");
        end

        // Kill while holding a result in FINISH
        begin
            int lat;
            start(ALU_REMU, 32'd100, 32'd7);
            wait_valid(lat);
            check("kill_finish_result", res, 32'd2);
            @(negedge clk);
            kill = 1'b1;
            @(posedge clk);
            #1;
            kill = 1'b0;
            check("kill_finish_valid", {31'd0, valid}, 32'd0);
            check("kill_finish_ready", {31'd0, ready}, 32'd1);
        end

        // Asynchronous reset mid-operation
        start(ALU_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_ready", {31'd0, ready}, 32'd1);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        check("midreset_result", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_valid_for(40, "midreset_no_valid");
        run_vec(vecs[3], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_cpu_div.md
RISCV_CPU_DIV -- requirements
Module: riscv_cpu_div

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 (package DATA_WIDTH), operand/result width.
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable_i  input  1  request valid from decode/EX.
REQ-005 SHALL have port operator_i  input  ALU_OP_WIDTH  alu_opcode_e; only ALU_DIVU/DIV/REMU/REM accepted.
REQ-006 SHALL have ports op_a_i, op_b_i  input  DATA_WIDTH  dividend, divisor.
REQ-007 SHALL have port kill_i  input  1  abort current operation (pipeline flush).
REQ-008 SHALL have port ex_ready_i  input  1  consumer accepts result.
REQ-009 SHALL have port ready_o  output  1  request acceptance, high only in IDLE.
REQ-010 SHALL have ports valid_o  output  1 and result_o  output  DATA_WIDTH  registered result.

Function
REQ-011 SHALL accept a request on a rising edge where enable_i, ready_o and a div/rem operator are all high and kill_i is low; other operators SHALL be ignored.
REQ-012 SHALL latch operands and operator on acceptance; operator bit0 = signed, bit1 = remainder.
REQ-013 SHALL implement states IDLE, DIVIDE, FINISH: IDLE->DIVIDE on accept; DIVIDE->FINISH when the iteration counter reaches 0; FINISH->IDLE when ex_ready_i is high.
REQ-014 SHALL perform radix-2 restoring division on operand magnitudes, one quotient bit per cycle, counter from DATA_WIDTH-1 down to 0.
REQ-015 SHALL assert valid_o exactly DATA_WIDTH cycles after the acceptance edge (32 for default).
REQ-016 SHALL negate the quotient when signed and operand signs differ; the remainder SHALL take the dividend's sign.
REQ-017 Divisor 0: quotient SHALL be all ones; remainder SHALL be op_a.
REQ-018 Signed overflow (0x80000000 / -1): quotient SHALL be 0x80000000; remainder SHALL be 0.
REQ-019 SHALL hold valid_o and result_o stable in FINISH while ex_ready_i is low.
REQ-020 FINISH with ex_ready_i high: SHALL return to IDLE; ready_o SHALL be low that cycle (no back-to-back accept).
REQ-021 kill_i SHALL have priority in every state: next edge state=IDLE, valid_o=0, no result delivered.

Reset
REQ-022 On rst_ni low, state SHALL be IDLE, counter 0, valid_o 0, result_o 0, ready_o 1, asynchronously.
REQ-023 Reset mid-operation SHALL discard the operation; no valid_o SHALL follow.

Configuration
REQ-024 Macro RISCV_CPU_DIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow SHALL go IDLE->FINISH on the acceptance edge, with valid_o high the following cycle.
REQ-025 Macro undefined: all cases SHALL take the full DATA_WIDTH-cycle latency; the special results of REQ-017/018 SHALL be unchanged.

Structure
REQ-026 riscv_cpu_pkg SHALL gain div_state_e (IDLE, DIVIDE, FINISH) and DIV_CNT_WIDTH = $clog2(DATA_WIDTH); opcodes SHALL come from the existing alu_opcode_e.
REQ-027 Sub-module riscv_cpu_div_sign_fix (combinational conditional two's-complement negate) SHALL be instantiated for operand magnitude and result sign correction.

Verification
REQ-028 DIVU 100/7 -> valid_o after 32 cycles, result 14; REMU same operands -> 2.
REQ-029 REM -7 (0xFFFFFFF9) by 2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD (-3).
REQ-030 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; with RISCV_CPU_DIV_EARLY_OUT_EN, valid_o 1 cycle after accept; without it, 32 cycles.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-032 kill_i at cycle 10 of DIVIDE -> IDLE next edge, ready_o 1, valid_o never asserts; next request completes correctly.
REQ-033 ex_ready_i held low 5 cycles in FINISH -> valid_o/result_o stable; enable_i high meanwhile is not accepted.
